// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fifo_reader_pkg
// Purpose  : Shared state encoding and sizing helper for the FIFO reader.
// Revision : 1.0 - initial release
// =============================================================================
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } readerState_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int occWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_reader_skid.sv
`default_nettype none
// =============================================================================
// Module   : fifo_reader_skid
// Purpose  : Small register buffer with first-word fall-through read port.
// Revision : 1.0 - initial release
// =============================================================================
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int SKID_DEPTH  = 4,
    parameter int COUNT_WIDTH = occWidth(SKID_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   empty
);

    localparam int               c_PTR_W    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(SKID_DEPTH - 1);

    logic [DATA_WIDTH-1:0]  r_mem [SKID_DEPTH];
    logic [c_PTR_W-1:0]     r_wrPtr;
    logic [c_PTR_W-1:0]     r_rdPtr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_rd;

    assign w_rd    = rd_en && (r_count != '0);
    assign rd_data = r_mem[r_rdPtr];
    assign count   = r_count;
    assign empty   = (r_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wrPtr] <= wr_data;
                r_wrPtr        <= (r_wrPtr == c_LAST_PTR) ? '0 : r_wrPtr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rdPtr <= (r_rdPtr == c_LAST_PTR) ? '0 : r_rdPtr + c_PTR_W'(1);
            end
            case ({wr_en, w_rd})
                2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
                2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// =============================================================================
// Module   : fifo_reader
// Purpose  : Drains N words per command from a fixed-latency FIFO into a
//            valid/ready stream. Optional macro FIFO_READER_UNDERRUN_CNT_EN
//            adds an underrun_cnt output.
// Revision : 1.0 - initial release
// =============================================================================
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int LEN_WIDTH    = 4,
    parameter int READ_LATENCY = 2,
    parameter int POP_GAP      = 3,
    parameter int SKID_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef FIFO_READER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]            underrun_cnt
`endif
);

    localparam int                 c_OCC_W      = occWidth(SKID_DEPTH);
    localparam int                 c_GAP_W      = $clog2(POP_GAP + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_RELOAD = c_GAP_W'(POP_GAP - 1);

    readerState_t           r_state;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [LEN_WIDTH-1:0]   r_sent;
    logic [c_GAP_W-1:0]     r_gapCnt;
    logic [READ_LATENCY-1:0] r_pipe;
    logic                   r_done;

    logic                   w_pop;
    logic                   w_xfer;
    logic                   w_empty;
    logic                   w_credit;
    logic [c_OCC_W-1:0]     w_count;
    logic [c_OCC_W-1:0]     w_outstanding;
    logic [c_OCC_W:0]       w_inUse;

    always_comb begin
        w_outstanding = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_outstanding = w_outstanding + c_OCC_W'(r_pipe[i]);
        end
    end

    // Words already requested count against space, so the buffer never overflows.
    assign w_inUse  = {1'b0, w_outstanding} + {1'b0, w_count};
    assign w_credit = (w_inUse < (c_OCC_W + 1)'(SKID_DEPTH));

    assign w_pop = (r_state == RUN) && (r_remaining != '0) && !fifo_empty
                && (r_gapCnt == '0) && w_credit;

    assign w_xfer    = !w_empty && out_ready;
    assign fifo_pop  = w_pop;
    assign out_valid = !w_empty;
    assign out_last  = !w_empty && (r_sent == LEN_WIDTH'(1));
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

    generate
        if (READ_LATENCY == 1) begin : g_pipeSingle
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) r_pipe <= '0;
                else        r_pipe <= w_pop;
            end
        end else begin : g_pipeShift
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) r_pipe <= '0;
                else        r_pipe <= {r_pipe[READ_LATENCY-2:0], w_pop};
            end
        end
    endgenerate

    fifo_reader_skid #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SKID_DEPTH  (SKID_DEPTH),
        .COUNT_WIDTH (c_OCC_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (r_pipe[READ_LATENCY-1]),
        .wr_data (fifo_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .count   (w_count),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_sent      <= '0;
            r_gapCnt    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_gapCnt <= c_GAP_RELOAD;
            end else if (r_gapCnt != '0) begin
                r_gapCnt <= r_gapCnt - c_GAP_W'(1);
            end
            if (w_xfer) begin
                r_sent <= r_sent - LEN_WIDTH'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_remaining <= length;
                            r_sent      <= length;
                            r_state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_pop) begin
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (r_sent == '0) r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_READER_UNDERRUN_CNT_EN
    logic [7:0] r_underrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_underrun <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_underrun <= '0;
        end else if ((r_state == RUN) && (r_remaining != '0) && fifo_empty
                     && (r_underrun != 8'hFF)) begin
            r_underrun <= r_underrun + 8'd1;
        end
    end

    assign underrun_cnt = r_underrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_fifo_reader
// Purpose  : Randomised scoreboard bench for fifo_reader with a FIFO model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fifo_reader;

    localparam int DW = 4;
    localparam int LW = 4;
    localparam int RL = 2;
    localparam int PG = 3;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_pop;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef FIFO_READER_UNDERRUN_CNT_EN
    logic [7:0]    underrun_cnt;
`endif

    fifo_reader #(
        .DATA_WIDTH   (DW),
        .LEN_WIDTH    (LW),
        .READ_LATENCY (RL),
        .POP_GAP      (PG),
        .SKID_DEPTH   (SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef FIFO_READER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] dataAt[int];
    exp_t          sbQ[$];
    int            popCycles[$];
    int            popCnt = 0;
    int            lastPopCyc = -100;
    int            doneCnt = 0;
    int            lastDoneCyc = 0;
    bit            validSeen = 0;
    bit            randReady = 0;
    bit            randEmpty = 0;
    bit            holdEmpty = 0;
    bit            prevStall = 0;
    logic [DW-1:0] prevData = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: empty flag and read data are driven just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (randEmpty) holdEmpty = ($urandom_range(0, 3) == 0);
        if (randReady) out_ready = $urandom_range(0, 1);
        fifo_empty = holdEmpty || (fifoQ.size() == 0);
        if (dataAt.exists(cyc)) begin
            fifo_data = dataAt[cyc];
            dataAt.delete(cyc);
        end else begin
            fifo_data = DW'($urandom);
        end
    end

    // Monitor: samples everything shortly before the rising edge.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (!reset) begin
            prevStall = 0;
        end else begin
            if (fifo_pop) begin
                chk("pop_while_empty", fifo_empty, 0);
                chk("pop_gap_ok", (cyc - lastPopCyc) >= PG, 1);
                popCnt++;
                popCycles.push_back(cyc);
                lastPopCyc = cyc;
                if (fifoQ.size() != 0) dataAt[cyc + RL] = fifoQ.pop_front();
            end
            if (out_valid) validSeen = 1;
            if (prevStall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prevData);
            end
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    chk("unexpected_word", out_data, 32'hFFFF_FFFF);
                end else begin
                    e = sbQ.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            if (done) begin
                doneCnt++;
                lastDoneCyc = cyc;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doStart(input int len);
        start  = 1'b1;
        length = LW'(len);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic expectWords(input logic [DW-1:0] ws[$], input bit toFifo);
        for (int i = 0; i < ws.size(); i++) begin
            sbQ.push_back('{data: ws[i], last: (i == ws.size() - 1)});
            if (toFifo) fifoQ.push_back(ws[i]);
        end
    endtask

    task automatic randWords(input int n, output logic [DW-1:0] ws[$]);
        ws = {};
        for (int i = 0; i < n; i++) ws.push_back(DW'($urandom));
    endtask

    task automatic waitDone(input string nm, input int d0, input int bound);
        int n = 0;
        while (doneCnt == d0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, (doneCnt != d0), 1);
        cycles(3);
        chk({nm, "_done_once"}, doneCnt - d0, 1);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_all_words"}, sbQ.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ws[$];
        int d0, p0, s0, n;

        #1;
        chk("rst_fifo_pop", fifo_pop, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        cycles(3);
        reset = 1'b1;
        cycles(2);

        // Basic burst with free-flowing output.
        ws = {4'd3, 4'd7, 4'd9, 4'd1};
        expectWords(ws, 1);
        popCycles = {};
        d0 = doneCnt; p0 = popCnt;
        doStart(4);
        waitDone("basic", d0, 100);
        chk("basic_pops", popCnt - p0, 4);
        for (int i = 1; i < popCycles.size(); i++)
            chk("basic_pop_spacing", popCycles[i] - popCycles[i-1], PG);

        // Zero-length command.
        cycles(3);
        d0 = doneCnt; p0 = popCnt; validSeen = 0;
        s0 = cyc;
        doStart(0);
        waitDone("len0", d0, 20);
        chk("len0_latency", lastDoneCyc - s0, 2);
        chk("len0_pops", popCnt - p0, 0);
        chk("len0_valid", validSeen, 0);

        // Full backpressure, then release.
        out_ready = 1'b0;
        randWords(8, ws);
        expectWords(ws, 1);
        d0 = doneCnt; p0 = popCnt;
        doStart(8);
        cycles(30);
        chk("bp_pops_capped", popCnt - p0, SD);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, ws[0]);
        out_ready = 1'b1;
        waitDone("bp", d0, 200);
        chk("bp_pops_total", popCnt - p0, 8);

        // FIFO empty for the first ten cycles of the burst.
        randWords(2, ws);
        expectWords(ws, 0);
        d0 = doneCnt; p0 = popCnt;
        doStart(2);
        cycles(10);
        chk("empty_no_pops", popCnt - p0, 0);
        for (int i = 0; i < ws.size(); i++) fifoQ.push_back(ws[i]);
        waitDone("empty", d0, 100);
        chk("empty_pops", popCnt - p0, 2);
`ifdef FIFO_READER_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, 10);
`endif

        // Reset in the middle of a burst with a word sitting in the buffer.
        out_ready = 1'b0;
        ws = {4'hA, 4'hB, 4'hC, 4'hD};
        expectWords(ws, 1);
        p0 = popCnt;
        doStart(4);
        n = 0;
        while (popCnt == p0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_first_pop", (popCnt != p0), 1);
        cycles(2);
        reset = 1'b0;
        #1;
        chk("rst_mid_fifo_pop", fifo_pop, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_data", out_data, 0);
        chk("rst_mid_out_last", out_last, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
`ifdef FIFO_READER_UNDERRUN_CNT_EN
        chk("rst_mid_underrun", underrun_cnt, 0);
`endif
        sbQ.delete();
        fifoQ.delete();
        dataAt.delete();
        lastPopCyc = -100;
        cycles(2);
        reset = 1'b1;
        out_ready = 1'b1;
        cycles(2);
        ws = {4'd5};
        expectWords(ws, 1);
        d0 = doneCnt; p0 = popCnt;
        doStart(1);
        waitDone("after_rst", d0, 50);
        chk("after_rst_pops", popCnt - p0, 1);

        // A second start while busy must be dropped.
        randWords(6, ws);
        for (int i = 0; i < 6; i++) fifoQ.push_back(ws[i]);
        ws = ws[0:2];
        expectWords(ws, 0);
        d0 = doneCnt; p0 = popCnt;
        doStart(3);
        cycles(2);
        doStart(5);
        waitDone("busy_start", d0, 100);
        cycles(10);
        chk("busy_start_pops", popCnt - p0, 3);
        chk("busy_start_left", fifoQ.size(), 3);
        fifoQ.delete();

        // Random bursts with random backpressure and empty-flag glitches.
        randReady = 1;
        randEmpty = 1;
        for (int b = 0; b < 8; b++) begin
            int len = $urandom_range(0, 15);
            randWords(len, ws);
            expectWords(ws, 1);
            d0 = doneCnt; p0 = popCnt;
            doStart(len);
            waitDone("rand", d0, 1500);
            chk("rand_pops", popCnt - p0, len);
        end
        randReady = 0;
        randEmpty = 0;
        holdEmpty = 0;

        // Maximum length burst.
        out_ready = 1'b1;
        randWords(15, ws);
        expectWords(ws, 1);
        d0 = doneCnt; p0 = popCnt;
        doStart(15);
        waitDone("maxlen", d0, 300);
        chk("maxlen_pops", popCnt - p0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
